// File: rtl/um_operand_fetch_if.sv
// Bus bundle between the UM operand-fetch sequencer and its neighbours
// (instruction source, register bank, execute stage).
interface um_operand_fetch_if;
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 3;
    localparam int unsigned OW = 4;

    logic          instr_valid;
    logic [DW-1:0] instr;
    logic          instr_ready;

    logic [DW-1:0] rb_data;
    logic [RW-1:0] rb_sel;
    logic          rb_mode;
    logic [DW-1:0] rb_q;

    logic          op_valid;
    logic          op_ready;
    logic [OW-1:0] op_code;
    logic [RW-1:0] op_a_sel;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [DW-1:0] op_c;
    logic [DW-1:0] op_imm;

    logic          wb_valid;
    logic [RW-1:0] wb_sel;
    logic [DW-1:0] wb_data;
    logic          wb_ready;

    modport master (
        input  instr_valid, instr, rb_q, op_ready, wb_valid, wb_sel, wb_data,
        output instr_ready, rb_data, rb_sel, rb_mode,
               op_valid, op_code, op_a_sel, op_a, op_b, op_c, op_imm, wb_ready
    );

    modport slave (
        output instr_valid, instr, rb_q, op_ready, wb_valid, wb_sel, wb_data,
        input  instr_ready, rb_data, rb_sel, rb_mode,
               op_valid, op_code, op_a_sel, op_a, op_b, op_c, op_imm, wb_ready
    );
endinterface

// File: rtl/um_operand_fetch.sv
// UM operand fetch: pipelined A/B/C reads from the register bank plus writeback arbitration.
// Define UM_FETCH_SKIP_EN to read only the operands each opcode consumes.
module um_operand_fetch (
    input  logic               clk,
    input  logic               reset,
    um_operand_fetch_if.master bus_io
);
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 3;
    localparam int unsigned OW = 4;
    localparam int unsigned IW = 25;
    localparam int unsigned SW = 3;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ISSUE_A  = 3'd1;
    localparam logic [2:0] S_ISSUE_B  = 3'd2;
    localparam logic [2:0] S_ISSUE_C  = 3'd3;
    localparam logic [2:0] S_CAP_LAST = 3'd4;
    localparam logic [2:0] S_PRESENT  = 3'd5;

    localparam logic [1:0] P_NONE = 2'd0;
    localparam logic [1:0] P_A    = 2'd1;
    localparam logic [1:0] P_B    = 2'd2;
    localparam logic [1:0] P_C    = 2'd3;

    localparam logic [OW-1:0] OPC_ORTHO = 4'd13;

    logic [SW-1:0] state_q, state_d;
    logic [1:0]    pend_q, pend_d;
    logic [2:0]    need_q, need_d;
    logic [RW-1:0] idx_a_q, idx_a_d;
    logic [RW-1:0] idx_b_q, idx_b_d;
    logic [RW-1:0] idx_c_q, idx_c_d;
    logic [OW-1:0] op_code_q, op_code_d;
    logic [RW-1:0] op_a_sel_q, op_a_sel_d;
    logic [DW-1:0] op_a_q, op_a_d;
    logic [DW-1:0] op_b_q, op_b_d;
    logic [DW-1:0] op_c_q, op_c_d;
    logic [DW-1:0] op_imm_q, op_imm_d;
    logic          op_valid_q, op_valid_d;

    logic          instr_ready_c;
    logic          accept_c;
    logic          wb_ok_c;
    logic          rb_mode_c;
    logic [RW-1:0] rb_sel_c;
    logic [DW-1:0] rb_data_c;
    logic [OW-1:0] opc_c;

    assign opc_c         = bus_io.instr[31:28];
    assign instr_ready_c = (state_q == S_IDLE) && !bus_io.wb_valid && !reset;
    assign accept_c      = bus_io.instr_valid && instr_ready_c;
    assign wb_ok_c       = !reset && bus_io.wb_valid &&
                           ((state_q == S_IDLE) || (state_q == S_PRESENT));

`ifdef UM_FETCH_SKIP_EN
    // Operand usage mask {A,B,C} per opcode.
    function automatic logic [2:0] need_of(input logic [OW-1:0] opc);
        case (opc)
            4'd0, 4'd2:                         need_of = 3'b111;
            4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd12: need_of = 3'b011;
            4'd8, 4'd9, 4'd10:                  need_of = 3'b001;
            default:                            need_of = 3'b000;
        endcase
    endfunction
`endif

    // First remaining read in A,B,C order; CAP_LAST when nothing is left.
    function automatic logic [SW-1:0] next_issue(input logic [2:0] need);
        if (need[2])      next_issue = S_ISSUE_A;
        else if (need[1]) next_issue = S_ISSUE_B;
        else if (need[0]) next_issue = S_ISSUE_C;
        else              next_issue = S_CAP_LAST;
    endfunction

    always_comb begin
        state_d    = state_q;
        pend_d     = P_NONE;
        need_d     = need_q;
        idx_a_d    = idx_a_q;
        idx_b_d    = idx_b_q;
        idx_c_d    = idx_c_q;
        op_code_d  = op_code_q;
        op_a_sel_d = op_a_sel_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_c_d     = op_c_q;
        op_imm_d   = op_imm_q;
        op_valid_d = op_valid_q;

        // Read data for the select issued last cycle arrives now.
        case (pend_q)
            P_A:     op_a_d = bus_io.rb_q;
            P_B:     op_b_d = bus_io.rb_q;
            P_C:     op_c_d = bus_io.rb_q;
            default: ;
        endcase

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    op_code_d  = opc_c;
                    op_a_sel_d = (opc_c == OPC_ORTHO) ? bus_io.instr[27:25] : bus_io.instr[8:6];
                    op_imm_d   = (opc_c == OPC_ORTHO) ? DW'(bus_io.instr[IW-1:0]) : '0;
                    idx_a_d    = bus_io.instr[8:6];
                    idx_b_d    = bus_io.instr[5:3];
                    idx_c_d    = bus_io.instr[2:0];
                    op_a_d     = '0;
                    op_b_d     = '0;
                    op_c_d     = '0;
`ifdef UM_FETCH_SKIP_EN
                    need_d     = need_of(opc_c);
`else
                    need_d     = 3'b111;
`endif
                    state_d    = next_issue(need_d);
                end
            end
            S_ISSUE_A: begin
                pend_d  = P_A;
                state_d = next_issue({1'b0, need_q[1:0]});
            end
            S_ISSUE_B: begin
                pend_d  = P_B;
                state_d = next_issue({2'b00, need_q[0]});
            end
            S_ISSUE_C: begin
                pend_d  = P_C;
                state_d = S_CAP_LAST;
            end
            S_CAP_LAST: begin
                state_d    = S_PRESENT;
                op_valid_d = 1'b1;
            end
            S_PRESENT: begin
                if (bus_io.op_ready) begin
                    state_d    = S_IDLE;
                    op_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Single bank master: writeback wins in IDLE/PRESENT, read selects in ISSUE states.
    always_comb begin
        rb_mode_c = 1'b0;
        rb_sel_c  = '0;
        rb_data_c = '0;
        if (wb_ok_c) begin
            rb_mode_c = 1'b1;
            rb_sel_c  = bus_io.wb_sel;
            rb_data_c = bus_io.wb_data;
        end else if (!reset) begin
            case (state_q)
                S_ISSUE_A: rb_sel_c = idx_a_q;
                S_ISSUE_B: rb_sel_c = idx_b_q;
                S_ISSUE_C: rb_sel_c = idx_c_q;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pend_q     <= P_NONE;
            need_q     <= '0;
            idx_a_q    <= '0;
            idx_b_q    <= '0;
            idx_c_q    <= '0;
            op_code_q  <= '0;
            op_a_sel_q <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_c_q     <= '0;
            op_imm_q   <= '0;
            op_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            need_q     <= need_d;
            idx_a_q    <= idx_a_d;
            idx_b_q    <= idx_b_d;
            idx_c_q    <= idx_c_d;
            op_code_q  <= op_code_d;
            op_a_sel_q <= op_a_sel_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_c_q     <= op_c_d;
            op_imm_q   <= op_imm_d;
            op_valid_q <= op_valid_d;
        end
    end

    assign bus_io.instr_ready = instr_ready_c;
    assign bus_io.wb_ready    = wb_ok_c;
    assign bus_io.rb_mode     = rb_mode_c;
    assign bus_io.rb_sel      = rb_sel_c;
    assign bus_io.rb_data     = rb_data_c;
    assign bus_io.op_valid    = op_valid_q;
    assign bus_io.op_code     = op_code_q;
    assign bus_io.op_a_sel    = op_a_sel_q;
    assign bus_io.op_a        = op_a_q;
    assign bus_io.op_b        = op_b_q;
    assign bus_io.op_c        = op_c_q;
    assign bus_io.op_imm      = op_imm_q;

endmodule

// File: tb/tb_um_operand_fetch.sv
// Directed self-checking bench for um_operand_fetch with a behavioural 8x32 register bank.
// Expectations adapt when UM_FETCH_SKIP_EN is defined.
module tb_um_operand_fetch;
`ifdef UM_FETCH_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk;
    logic reset;
    int   npass = 0;
    int   nfail = 0;
    int   ntot  = 0;
    int   nwr   = 0;

    logic [31:0] mem [8] = '{32'h0000_0000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                             32'h4444_4444, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777};

    um_operand_fetch_if bus ();

    um_operand_fetch dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank: synchronous write, registered read one cycle after select.
    always @(posedge clk) begin
        if (bus.rb_mode === 1'b1) begin
            mem[bus.rb_sel] <= bus.rb_data;
            nwr             <= nwr + 1;
        end
        bus.rb_q <= mem[bus.rb_sel];
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (bus.op_valid !== 1'b1 && lat < 12) begin
            cyc();
            lat++;
        end
    endtask

    int lat;
    int n;
    int bad;

    initial begin
        reset           = 1'b1;
        bus.instr_valid = 1'b1;
        bus.instr       = 32'h3000_005B;
        bus.op_ready    = 1'b0;
        bus.wb_valid    = 1'b1;
        bus.wb_sel      = 3'd2;
        bus.wb_data     = 32'hDEAD_BEEF;
        cyc();
        cyc();
        chk("rst_instr_ready", 32'(bus.instr_ready), 32'd0);
        chk("rst_wb_ready",    32'(bus.wb_ready),    32'd0);
        chk("rst_rb_mode",     32'(bus.rb_mode),     32'd0);
        chk("rst_rb_sel",      32'(bus.rb_sel),      32'd0);
        chk("rst_rb_data",     bus.rb_data,          32'd0);
        chk("rst_op_valid",    32'(bus.op_valid),    32'd0);
        chk("rst_op_a",        bus.op_a,             32'd0);
        chk("rst_op_imm",      bus.op_imm,           32'd0);
        chk("rst_no_write",    32'(nwr),             32'd0);
        bus.instr_valid = 1'b0;
        bus.wb_valid    = 1'b0;
        reset           = 1'b0;

        // Writeback r3 = 0xAA from IDLE
        bus.wb_valid = 1'b1;
        bus.wb_sel   = 3'd3;
        bus.wb_data  = 32'h0000_00AA;
        #1;
        chk("wb_ready_idle", 32'(bus.wb_ready),    32'd1);
        chk("wb_rb_mode",    32'(bus.rb_mode),     32'd1);
        chk("wb_rb_sel",     32'(bus.rb_sel),      32'd3);
        chk("wb_rb_data",    bus.rb_data,          32'h0000_00AA);
        chk("wb_blocks_ir",  32'(bus.instr_ready), 32'd0);
        cyc();
        bus.wb_valid = 1'b0;
        #1;
        chk("wb_r3_landed", mem[3], 32'h0000_00AA);

        // add: op 3, A=1, B=3, C=3
        bus.instr       = 32'h3000_005B;
        bus.instr_valid = 1'b1;
        #1;
        chk("add_ready", 32'(bus.instr_ready), 32'd1);
        cyc();
        bus.instr_valid = 1'b0;
        #1;
        chk("add_first_sel",  32'(bus.rb_sel),  SKIP ? 32'd3 : 32'd1);
        chk("add_first_mode", 32'(bus.rb_mode), 32'd0);
        wait_valid(lat);
        chk("add_latency", 32'(lat), SKIP ? 32'd3 : 32'd4);
        chk("add_op_code", 32'(bus.op_code),  32'd3);
        chk("add_a_sel",   32'(bus.op_a_sel), 32'd1);
        chk("add_op_a",    bus.op_a, SKIP ? 32'd0 : 32'h1111_1111);
        chk("add_op_b",    bus.op_b, 32'h0000_00AA);
        chk("add_op_c",    bus.op_c, 32'h0000_00AA);
        chk("add_op_imm",  bus.op_imm, 32'd0);

        // Back-pressure: five cycles with op_ready low
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (bus.op_valid !== 1'b1 || bus.op_b !== 32'h0000_00AA ||
                bus.op_c !== 32'h0000_00AA || bus.instr_ready !== 1'b0) bad++;
        end
        chk("hold_stable", 32'(bad), 32'd0);
        bus.op_ready = 1'b1;
        cyc();
        bus.op_ready = 1'b0;
        #1;
        chk("release_valid", 32'(bus.op_valid),    32'd0);
        chk("release_idle",  32'(bus.instr_ready), 32'd1);

        // Orthography 0xD2AB_CDEF
        bus.instr       = 32'hD2AB_CDEF;
        bus.instr_valid = 1'b1;
        cyc();
        bus.instr_valid = 1'b0;
        wait_valid(lat);
        chk("ortho_latency", 32'(lat), SKIP ? 32'd1 : 32'd4);
        chk("ortho_op_code", 32'(bus.op_code),  32'd13);
        chk("ortho_a_sel",   32'(bus.op_a_sel), 32'd1);
        chk("ortho_imm",     bus.op_imm, 32'h00AB_CDEF);
        chk("ortho_op_a",    bus.op_a, SKIP ? 32'd0 : 32'h7777_7777);
        chk("ortho_op_b",    bus.op_b, SKIP ? 32'd0 : 32'h5555_5555);
        bus.op_ready = 1'b1;
        cyc();
        bus.op_ready = 1'b0;

        // Writeback raised during ISSUE_B of op 0, A=2, B=4, C=6
        bus.instr       = 32'h0000_00A6;
        bus.instr_valid = 1'b1;
        cyc();
        bus.instr_valid = 1'b0;
        cyc();
        bus.wb_valid = 1'b1;
        bus.wb_sel   = 3'd6;
        bus.wb_data  = 32'hCAFE_0006;
        #1;
        n   = 0;
        bad = 0;
        while (bus.wb_ready !== 1'b1 && n < 10) begin
            if (bus.rb_mode !== 1'b0) bad++;
            cyc();
            n++;
        end
        chk("wb_wait_cycles",   32'(n),   32'd3);
        chk("wb_no_mode_reads", 32'(bad), 32'd0);
        chk("wb_present_valid", 32'(bus.op_valid), 32'd1);
        chk("wb_present_sel",   32'(bus.rb_sel),   32'd6);
        cyc();
        bus.wb_valid = 1'b0;
        #1;
        chk("wb_r6_landed", mem[6], 32'hCAFE_0006);
        chk("wb_count_2",   32'(nwr), 32'd2);
        chk("wbb_op_a",     bus.op_a, 32'h2222_2222);
        chk("wbb_op_b",     bus.op_b, 32'h4444_4444);
        chk("wbb_op_c",     bus.op_c, 32'h6666_6666);
        bus.op_ready = 1'b1;
        cyc();
        bus.op_ready = 1'b0;

        // Writeback r5 and instruction offered together: write goes first
        bus.wb_valid    = 1'b1;
        bus.wb_sel      = 3'd5;
        bus.wb_data     = 32'h1234_5678;
        bus.instr       = 32'h0000_016D;
        bus.instr_valid = 1'b1;
        #1;
        chk("prio_instr_ready", 32'(bus.instr_ready), 32'd0);
        chk("prio_wb_ready",    32'(bus.wb_ready),    32'd1);
        cyc();
        bus.wb_valid = 1'b0;
        #1;
        chk("prio_then_ready", 32'(bus.instr_ready), 32'd1);
        cyc();
        bus.instr_valid = 1'b0;
        wait_valid(lat);
        chk("raw_latency", 32'(lat), 32'd4);
        chk("raw_op_a",    bus.op_a, 32'h1234_5678);
        chk("raw_op_b",    bus.op_b, 32'h1234_5678);
        chk("raw_op_c",    bus.op_c, 32'h1234_5678);
        chk("wb_count_3",  32'(nwr), 32'd3);
        bus.op_ready = 1'b1;
        cyc();
        bus.op_ready = 1'b0;

        // Reset while in ISSUE_C of op 0, A=1, B=2, C=3
        bus.instr       = 32'h0000_0053;
        bus.instr_valid = 1'b1;
        cyc();
        bus.instr_valid = 1'b0;
        cyc();
        cyc();
        chk("abort_in_issue_c", 32'(bus.rb_sel), 32'd3);
        reset        = 1'b1;
        bus.wb_valid = 1'b1;
        bus.wb_sel   = 3'd1;
        bus.wb_data  = 32'hFFFF_FFFF;
        #1;
        chk("abort_rst_mode", 32'(bus.rb_mode),  32'd0);
        chk("abort_rst_wbr",  32'(bus.wb_ready), 32'd0);
        cyc();
        reset        = 1'b0;
        bus.wb_valid = 1'b0;
        #1;
        chk("abort_op_valid", 32'(bus.op_valid),    32'd0);
        chk("abort_op_a",     bus.op_a,             32'd0);
        chk("abort_rb_sel",   32'(bus.rb_sel),      32'd0);
        chk("abort_idle",     32'(bus.instr_ready), 32'd1);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (bus.op_valid !== 1'b0) bad++;
        end
        chk("abort_no_present", 32'(bad), 32'd0);
        chk("abort_wr_count",   32'(nwr), 32'd3);
        chk("abort_r1_intact",  mem[1],   32'h1111_1111);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
